// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the digit-serial packed-BCD adder:
//   - state_t      : sequencing FSM states (IDLE / RUN / DONE)
//   - BCD_MAX      : largest legal decimal digit value (9)
//   - BCD_ADJ      : correction added to a binary digit sum above 9 (6)
//   - is_bcd_digit : returns 1 when a 4-bit nibble is a legal BCD digit
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Both constants are 5 bits wide so they compare/add directly against the
  // 5-bit raw digit sum without implicit widening.
  localparam logic [4:0] BCD_MAX = 5'd9;
  localparam logic [4:0] BCD_ADJ = 5'd6;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    logic ok;
    if (d <= BCD_MAX[3:0]) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Purely combinational single-digit decimal adder.
//   a, b  (in,  4) : operand digits (values above 9 are accepted and handled
//                    by the same rule, giving a deterministic non-BCD result)
//   cin   (in,  1) : decimal carry-in
//   digit (out, 4) : result digit
//   cout  (out, 1) : decimal carry-out
// Rule: t = a + b + cin (5-bit). If t > 9 the digit is (t + 6) mod 16 and the
// carry is 1, otherwise the digit is t[3:0] and the carry is 0.
// ---------------------------------------------------------------------------
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] raw_sum_s;
  logic [4:0] adj_sum_s;

  // Binary sum of the digit pair plus carry, and its decimal-corrected form.
  always_comb begin
    raw_sum_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    // Only the low nibble of the corrected value is used, so wrap past
    // 5 bits is harmless (max raw sum is 31).
    adj_sum_s = raw_sum_s + BCD_ADJ;
  end

  // Decimal carry decision and digit select.
  always_comb begin
    digit = 4'd0;
    cout  = 1'b0;
    if (raw_sum_s > BCD_MAX) begin
      digit = adj_sum_s[3:0];
      cout  = 1'b1;
    end else begin
      digit = raw_sum_s[3:0];
      cout  = 1'b0;
    end
  end

endmodule : bcd_digit_add

// File: rtl/bcd_seq_adder.sv
// ---------------------------------------------------------------------------
// bcd_seq_adder
// Digit-serial multi-digit packed-BCD adder. Adds two DIGITS-wide packed-BCD
// operands plus a carry-in, one decimal digit per clock from the least
// significant digit upward, using a single shared bcd_digit_add instance.
//
// Ports:
//   clk     (in,  1)          rising-edge clock
//   rst_n   (in,  1)          asynchronous active-low reset
//   start   (in,  1)          operation request, honoured only in IDLE
//   a       (in,  4*DIGITS)   operand A, digit 0 in [3:0]
//   b       (in,  4*DIGITS)   operand B
//   cin     (in,  1)          decimal carry-in
//   busy    (out, 1)          high while digits are being processed
//   done    (out, 1)          one-cycle pulse; sum/cout/invalid valid here
//   sum     (out, 4*DIGITS)   packed-BCD result
//   cout    (out, 1)          decimal carry-out of the top digit
//   invalid (out, 1)          some accepted digit of a or b was above 9
//
// Timing: start accepted at edge 0 -> RUN handles digit k at edge k+1, the
// last digit lands at edge DIGITS together with the move to DONE, so done is
// high in the cycle after edge DIGITS. DONE always returns to IDLE, giving a
// back-to-back period of DIGITS+2 cycles.
// ---------------------------------------------------------------------------
module bcd_seq_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int W     = 4 * DIGITS;
  // A single-digit adder still needs a 1-bit index register.
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Sequencing state
  state_t           state_r;
  state_t           state_nxt_s;
  logic             busy_r;
  logic             done_r;

  // Datapath registers
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     sum_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic             cout_r;
  logic             invalid_r;

  // Combinational helpers
  logic             accept_s;
  logic             last_digit_s;
  logic             bad_digit_s;
  logic [3:0]       dig_a_s;
  logic [3:0]       dig_b_s;
  logic [3:0]       dig_sum_s;
  logic             dig_cout_s;

  // Handshake qualifiers: a start only counts in IDLE, and RUN ends on the
  // top digit.
  always_comb begin
    accept_s     = 1'b0;
    last_digit_s = 1'b0;
    if (state_r == IDLE) begin
      accept_s = start;
    end else begin
      accept_s = 1'b0;
    end
    if (idx_r == IDX_LAST) begin
      last_digit_s = 1'b1;
    end else begin
      last_digit_s = 1'b0;
    end
  end

  // Scan the incoming operands for any nibble outside 0..9.
  always_comb begin
    bad_digit_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad_digit_s = bad_digit_s
                  | ~is_bcd_digit(a[4*i +: 4])
                  | ~is_bcd_digit(b[4*i +: 4]);
    end
  end

  // Select the current digit pair from the latched operands.
  always_comb begin
    dig_a_s = a_r[{idx_r, 2'b00} +: 4];
    dig_b_s = b_r[{idx_r, 2'b00} +: 4];
  end

  bcd_digit_add u_digit_add (
    .a     (dig_a_s),
    .b     (dig_b_s),
    .cin   (carry_r),
    .digit (dig_sum_s),
    .cout  (dig_cout_s)
  );

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_digit_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register with registered busy/done decoded from the next state,
  // so both outputs change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand capture on accept; operands are ignored at every other time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      invalid_r <= 1'b0;
    end else if (accept_s) begin
      a_r       <= a;
      b_r       <= b;
      invalid_r <= bad_digit_s;
    end else begin
      a_r       <= a_r;
      b_r       <= b_r;
      invalid_r <= invalid_r;
    end
  end

  // Digit sequencing: index, ripple carry, progressive sum and final carry.
  // cout only moves on the last RUN cycle so it holds across DONE/IDLE and
  // through the RUN phase of the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= IDX_ZERO;
      carry_r <= 1'b0;
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            idx_r   <= IDX_ZERO;
            carry_r <= cin;
            sum_r   <= {W{1'b0}};
          end else begin
            idx_r   <= idx_r;
            carry_r <= carry_r;
            sum_r   <= sum_r;
          end
        end
        RUN: begin
          sum_r[{idx_r, 2'b00} +: 4] <= dig_sum_s;
          carry_r                    <= dig_cout_s;
          idx_r                      <= idx_r + IDX_ONE;
          if (last_digit_s) begin
            cout_r <= dig_cout_s;
          end else begin
            cout_r <= cout_r;
          end
        end
        DONE: begin
          idx_r   <= idx_r;
          carry_r <= carry_r;
          sum_r   <= sum_r;
        end
        default: begin
          idx_r   <= IDX_ZERO;
          carry_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign sum     = sum_r;
  assign cout    = cout_r;
  assign invalid = invalid_r;

endmodule : bcd_seq_adder
